// File: rtl/ft_cmd_pkg.sv
// rtl/ft_cmd_pkg.sv - shared constants and state types for the FT command scheduler
// Purpose: opcode values, parser and TX arbiter state encodings, response length.
// Ports: none (package).
package ft_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'hA5;
  localparam logic [7:0] OP_READ  = 8'h5A;

  // Read response on the TX FIFO: opcode echo, address, data.
  localparam int RESP_LEN = 3;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    RESP
  } parse_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RESP,
    T_STREAM
  } tx_state_t;

endpackage

// File: rtl/ft_tx_arb.sv
// rtl/ft_tx_arb.sv - TX FIFO arbiter between read responses and the bulk stream
// Purpose: grants the TX FIFO write side to either the 3-byte read response or
//          the pixel stream; the response wins whenever both wait in T_IDLE.
//          A stream grant lasts until stream_last or MAX_BURST bytes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   resp_req                 parser has a response waiting
//   resp_addr, resp_data     payload bytes 2 and 3 of the response
//   resp_done                pulses with the write of the last response byte
//   stream_valid/data/last   stream source
//   stream_ready             stream byte accepted when high with stream_valid
//   tx_full                  TX FIFO full
//   tx_wrreq, tx_data        TX FIFO write side
module ft_tx_arb #(
  parameter int MAX_BURST = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       resp_req,
  input  logic [7:0] resp_addr,
  input  logic [7:0] resp_data,
  output logic       resp_done,
  input  logic       stream_valid,
  input  logic [7:0] stream_data,
  input  logic       stream_last,
  output logic       stream_ready,
  input  logic       tx_full,
  output logic       tx_wrreq,
  output logic [7:0] tx_data
);
  import ft_cmd_pkg::*;

  localparam int BW = $clog2(MAX_BURST + 1);

  tx_state_t     state, state_nxt;
  logic [1:0]    idx;
  logic [BW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= T_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // Both counters restart on every pass through T_IDLE, i.e. every grant.
      if (state == T_IDLE) begin
        idx <= '0;
        cnt <= '0;
      end else if (tx_wrreq) begin
        if (state == T_RESP) idx <= idx + 2'd1;
        else                 cnt <= cnt + BW'(1);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_wrreq     = 1'b0;
    tx_data      = 8'h00;
    stream_ready = 1'b0;
    resp_done    = 1'b0;
    case (state)
      T_IDLE: begin
        if (resp_req)          state_nxt = T_RESP;
        else if (stream_valid) state_nxt = T_STREAM;
      end
      T_RESP: begin
        // idx only advances on an actual write, so a full FIFO just freezes it.
        tx_wrreq = ~tx_full;
        case (idx)
          2'd0:    tx_data = OP_READ;
          2'd1:    tx_data = resp_addr;
          default: tx_data = resp_data;
        endcase
        if (tx_wrreq && idx == 2'(RESP_LEN - 1)) begin
          resp_done = 1'b1;
          state_nxt = T_IDLE;
        end
      end
      T_STREAM: begin
        stream_ready = ~tx_full;
        tx_wrreq     = stream_valid & ~tx_full;
        tx_data      = stream_data;
        if (tx_wrreq && (stream_last || cnt == BW'(MAX_BURST - 1)))
          state_nxt = T_IDLE;
      end
      default: state_nxt = T_IDLE;
    endcase
  end

endmodule

// File: rtl/ft_cmd_sched.sv
// rtl/ft_cmd_sched.sv - FT command parser, register bridge and TX scheduler (top)
// Purpose: reads write (A5 addr data) and read (5A addr) commands from the RX
//          FIFO, drives the register bus, and returns read data as 5A addr data
//          through ft_tx_arb, which shares the TX FIFO with the pixel stream.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   rx_empty, rx_data, rx_rdreq     RX FIFO read side (non-showahead)
//   tx_full, tx_wrreq, tx_data      TX FIFO write side
//   reg_addr, reg_wdata, reg_we     register bus, reg_rdata one cycle latency
//   stream_valid/data/last/ready    bulk stream toward the PC
//   busy                            parser not in IDLE
//   err_cnt                         saturating protocol error count
// Option: define FT_CMD_TIMEOUT_EN to abort partial commands after
//         TIMEOUT_CYCLES consecutive empty-FIFO cycles.
module ft_cmd_sched #(
  parameter int MAX_BURST      = 512,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_rdreq,
  input  logic       tx_full,
  output logic       tx_wrreq,
  output logic [7:0] tx_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  input  logic       stream_valid,
  input  logic [7:0] stream_data,
  input  logic       stream_last,
  output logic       stream_ready,
  output logic       busy,
  output logic [7:0] err_cnt
);
  import ft_cmd_pkg::*;

  if (MAX_BURST < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ft_cmd_sched: MAX_BURST and TIMEOUT_CYCLES must be at least 1");
  end

  parse_state_t state, state_nxt;
  logic         byte_vld;   // rx_data holds the byte requested last cycle
  logic         is_write;
  logic         rd_wait;    // second READ cycle: reg_rdata is valid
  logic [7:0]   rdata_q;
  logic         bad_op;
  logic         to_abort;
  logic         resp_done;
  logic         fetch;

  assign fetch  = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
  assign busy   = (state != IDLE);
  assign reg_we = (state == WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_rdreq  <= 1'b0;
      byte_vld  <= 1'b0;
      is_write  <= 1'b0;
      rd_wait   <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      rdata_q   <= 8'h00;
      err_cnt   <= 8'h00;
    end else begin
      state <= state_nxt;
      // One request at a time: no new request while one is pending or its
      // byte is being consumed, so a state change never strands a byte.
      rx_rdreq <= fetch && !rx_empty && !rx_rdreq && !byte_vld && !to_abort;
      byte_vld <= rx_rdreq;
      rd_wait  <= (state == READ) && !rd_wait;
      if (byte_vld) begin
        case (state)
          IDLE:     is_write  <= (rx_data == OP_WRITE);
          GET_ADDR: reg_addr  <= rx_data;
          GET_DATA: reg_wdata <= rx_data;
          default:  ;
        endcase
      end
      if (state == READ && rd_wait) rdata_q <= reg_rdata;
      if ((bad_op || to_abort) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    bad_op    = 1'b0;
    case (state)
      IDLE: begin
        if (byte_vld) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) state_nxt = GET_ADDR;
          else                                           bad_op    = 1'b1;
        end
      end
      GET_ADDR: if (byte_vld) state_nxt = is_write ? GET_DATA : READ;
      GET_DATA: if (byte_vld) state_nxt = WRITE;
      WRITE:    state_nxt = IDLE;
      READ:     if (rd_wait) state_nxt = RESP;
      RESP:     if (resp_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (to_abort) state_nxt = IDLE;
  end

`ifdef FT_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          starving;

  // Only cycles where the parser is truly waiting on an empty FIFO count.
  assign starving = (state == GET_ADDR || state == GET_DATA) && rx_empty &&
                    !rx_rdreq && !byte_vld;
  assign to_abort = starving && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !starving || to_abort) idle_cnt <= '0;
    else                              idle_cnt <= idle_cnt + TW'(1);
  end
`else
  assign to_abort = 1'b0;
`endif

  ft_tx_arb #(
    .MAX_BURST (MAX_BURST)
  ) u_tx_arb (
    .clk          (clk),
    .rst          (rst),
    .resp_req     (state == RESP),
    .resp_addr    (reg_addr),
    .resp_data    (rdata_q),
    .resp_done    (resp_done),
    .stream_valid (stream_valid),
    .stream_data  (stream_data),
    .stream_last  (stream_last),
    .stream_ready (stream_ready),
    .tx_full      (tx_full),
    .tx_wrreq     (tx_wrreq),
    .tx_data      (tx_data)
  );

endmodule
